// File: rtl/disp_pkg.sv
// Shared types and constants for the display scheduler: FSM states, slot
// count/index width and the blank display value.
package disp_pkg;

  localparam int C_NUM_SRC = 4;
  localparam int C_IDX_W   = 2;

  localparam logic [7:0] C_BLANK = 8'h00;

  typedef enum logic {
    IDLE,
    SHOW
  } state_t;

endpackage

// File: rtl/disp_scheduler_if.sv
// Requester/display bundle between the sources and the display scheduler.
// The master side drives requests and mode; the slave side returns acks and the shown value.
interface disp_scheduler_if;
  import disp_pkg::*;

  logic [C_NUM_SRC-1:0]   I_req;
  logic [8*C_NUM_SRC-1:0] I_data;
  logic [C_NUM_SRC-1:0]   I_clr;
  logic                   I_pin_en;
  logic [C_IDX_W-1:0]     I_pin_sel;
  logic [C_NUM_SRC-1:0]   O_ack;
  logic [7:0]             O_show_num;
  logic [C_IDX_W-1:0]     O_src;
  logic                   O_busy;

  modport master (
    output I_req, I_data, I_clr, I_pin_en, I_pin_sel,
    input  O_ack, O_show_num, O_src, O_busy
  );

  modport slave (
    input  I_req, I_data, I_clr, I_pin_en, I_pin_sel,
    output O_ack, O_show_num, O_src, O_busy
  );

endinterface

// File: rtl/disp_scheduler_rr_pick.sv
// Round-robin picker: first valid index strictly after start, wrapping,
// with start itself considered last.
module rr_pick
  import disp_pkg::*;
(
  input  logic [C_NUM_SRC-1:0] vld,
  input  logic [C_IDX_W-1:0]   start,
  output logic [C_IDX_W-1:0]   idx,
  output logic                 found
);

  logic [C_IDX_W-1:0] cand;

  // Scan farthest-first so the nearest valid candidate is the last one written.
  always_comb begin
    idx   = start;
    found = |vld;
    cand  = start;
    for (int k = C_NUM_SRC; k >= 1; k--) begin
      cand = start + C_IDX_W'(k);
      if (vld[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/disp_scheduler.sv
// Time-shares the seven-segment display among four requesters: per-source
// slots written via req/ack, shown round-robin with a dwell time or pinned.
module disp_scheduler
  import disp_pkg::*;
#(
  parameter int C_DWELL = 50_000_000,
  parameter int C_CNT_W = 32
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
  disp_scheduler_if.slave  bus
);

  logic [7:0]           slot_data [C_NUM_SRC];
  logic [C_NUM_SRC-1:0] slot_vld;
  logic [C_NUM_SRC-1:0] ack_q;

  state_t               state, nxt_state;
  logic [C_IDX_W-1:0]   cur, nxt_cur;
  logic [C_CNT_W-1:0]   cnt, nxt_cnt;
  logic [C_IDX_W-1:0]   pick_start, pick_idx;
  logic                 pick_found;

  logic                 busy_q;
  logic [7:0]           show_q;
  logic [C_IDX_W-1:0]   src_q;

  // A clear beats a coinciding capture; a held request re-captures every other cycle.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      slot_vld <= '0;
      ack_q    <= '0;
      for (int i = 0; i < C_NUM_SRC; i++) slot_data[i] <= '0;
    end else begin
      for (int i = 0; i < C_NUM_SRC; i++) begin
        ack_q[i] <= bus.I_req[i] && !ack_q[i] && !bus.I_clr[i];
        if (bus.I_clr[i]) begin
          slot_vld[i] <= 1'b0;
        end else if (bus.I_req[i] && !ack_q[i]) begin
          slot_vld[i]  <= 1'b1;
          slot_data[i] <= bus.I_data[8*i +: 8];
        end
      end
    end
  end

  // Starting the search just before slot 0 yields the lowest valid index from IDLE.
  assign pick_start = (state == IDLE) ? C_IDX_W'(C_NUM_SRC - 1) : cur;

  rr_pick u_rr_pick (
    .vld   (slot_vld),
    .start (pick_start),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_comb begin
    nxt_state = state;
    nxt_cur   = cur;
    nxt_cnt   = '0;
    case (state)
      IDLE: begin
        if (bus.I_pin_en) begin
          if (slot_vld[bus.I_pin_sel]) begin
            nxt_state = SHOW;
            nxt_cur   = bus.I_pin_sel;
          end
        end else if (pick_found) begin
          nxt_state = SHOW;
          nxt_cur   = pick_idx;
        end
      end
      SHOW: begin
        if (bus.I_pin_en) begin
          if (slot_vld[bus.I_pin_sel]) nxt_cur = bus.I_pin_sel;
          else nxt_state = IDLE;
        end else if (!slot_vld[cur]) begin
          if (pick_found) nxt_cur = pick_idx;
          else nxt_state = IDLE;
        end else if (cnt == C_CNT_W'(C_DWELL - 1)) begin
          nxt_cur = pick_idx;
        end else begin
          nxt_cnt = cnt + C_CNT_W'(1);
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // Outputs follow the next slot so a rewrite of the shown slot appears one edge later.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state  <= IDLE;
      cur    <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      show_q <= C_BLANK;
      src_q  <= '0;
    end else begin
      state  <= nxt_state;
      cur    <= nxt_cur;
      cnt    <= nxt_cnt;
      busy_q <= (nxt_state == SHOW);
      show_q <= (nxt_state == SHOW) ? slot_data[nxt_cur] : C_BLANK;
      src_q  <= nxt_cur;
    end
  end

  assign bus.O_ack      = ack_q;
  assign bus.O_show_num = show_q;
  assign bus.O_src      = src_q;
  assign bus.O_busy     = busy_q;

endmodule

// File: tb/tb_disp_scheduler.sv
// Scoreboard bench for disp_scheduler: a slot/dwell model predicts each cycle's
// outputs into a queue, and a monitor pops and compares after every clock edge.
module tb_disp_scheduler;
  import disp_pkg::*;

  localparam int DW = 4;

  typedef struct {
    logic [3:0] ack;
    logic [7:0] show;
    logic [1:0] src;
    logic       busy;
  } exp_t;

  logic I_clk   = 1'b0;
  logic I_rst_n = 1'b0;

  disp_scheduler_if bus ();

  disp_scheduler #(.C_DWELL(DW), .C_CNT_W(8)) dut (
    .I_clk   (I_clk),
    .I_rst_n (I_rst_n),
    .bus     (bus.slave)
  );

  always #5 I_clk = ~I_clk;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: slot contents, what is on screen, and cycles left on screen.
  logic [7:0] m_data [4];
  bit         m_vld  [4];
  bit   [3:0] m_ack;
  bit         m_busy;
  int         m_cur;
  int         m_left;

  logic       pin_en_k  = 1'b0;
  logic [1:0] pin_sel_k = 2'd0;

  task automatic modelReset();
    for (int i = 0; i < 4; i++) begin
      m_data[i] = 8'h00;
      m_vld[i]  = 1'b0;
    end
    m_ack  = '0;
    m_busy = 1'b0;
    m_cur  = 0;
    m_left = DW;
  endtask

  function automatic int findAfter(input int from);
    for (int k = 1; k <= 4; k++)
      if (m_vld[(from + k) % 4]) return (from + k) % 4;
    return -1;
  endfunction

  function automatic int lowestValid();
    for (int i = 0; i < 4; i++) if (m_vld[i]) return i;
    return -1;
  endfunction

  task automatic modelStep(input logic [3:0] req, input logic [31:0] data,
                           input logic [3:0] clr, input logic pin_en,
                           input logic [1:0] pin_sel);
    int         nc;
    int         nleft;
    bit         nb;
    bit   [3:0] nack;
    exp_t       e;
    nb = m_busy; nc = m_cur; nleft = m_left;
    if (!m_busy) begin
      if (pin_en) begin
        if (m_vld[pin_sel]) begin nb = 1; nc = int'(pin_sel); nleft = DW; end
      end else if (lowestValid() >= 0) begin
        nb = 1; nc = lowestValid(); nleft = DW;
      end
    end else if (pin_en) begin
      if (m_vld[pin_sel]) begin nc = int'(pin_sel); nleft = DW; end
      else nb = 0;
    end else if (!m_vld[m_cur]) begin
      if (findAfter(m_cur) >= 0) begin nc = findAfter(m_cur); nleft = DW; end
      else nb = 0;
    end else if (m_left == 1) begin
      nc = findAfter(m_cur); nleft = DW;
    end else begin
      nleft = m_left - 1;
    end
    e.show = nb ? m_data[nc] : 8'h00;
    for (int i = 0; i < 4; i++) begin
      nack[i] = req[i] && !m_ack[i] && !clr[i];
      if (clr[i]) m_vld[i] = 1'b0;
      else if (nack[i]) begin
        m_vld[i]  = 1'b1;
        m_data[i] = data[8*i +: 8];
      end
    end
    m_ack = nack; m_busy = nb; m_cur = nc; m_left = nleft;
    e.ack  = nack;
    e.src  = nc[1:0];
    e.busy = nb;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic [31:0] data,
                               input logic [3:0] clr, input logic pin_en,
                               input logic [1:0] pin_sel);
    @(negedge I_clk);
    bus.I_req = req; bus.I_data = data; bus.I_clr = clr;
    bus.I_pin_en = pin_en; bus.I_pin_sel = pin_sel;
    modelStep(req, data, clr, pin_en, pin_sel);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) applyStimulus(4'h0, 32'h0, 4'h0, pin_en_k, pin_sel_k);
  endtask

  task automatic checkField(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField("ack",      32'(bus.O_ack),      32'(e.ack));
    checkField("show_num", 32'(bus.O_show_num), 32'(e.show));
    checkField("busy",     32'(bus.O_busy),     32'(e.busy));
    checkField("src",      32'(bus.O_src),      32'(e.src));
  endtask

  task automatic releaseReset();
    @(negedge I_clk);
    I_rst_n = 1'b1;
    bus.I_req = '0; bus.I_data = '0; bus.I_clr = '0; bus.I_pin_en = 1'b0; bus.I_pin_sel = '0;
    pin_en_k = 1'b0; pin_sel_k = 2'd0;
    modelReset();
    modelStep(4'h0, 32'h0, 4'h0, 1'b0, 2'd0);
  endtask

  task automatic randomPhase(input int n);
    logic [3:0] req, clr;
    for (int c = 0; c < n; c++) begin
      if (c % 30 == 0) begin
        pin_en_k  = ($urandom_range(0, 2) == 0);
        pin_sel_k = 2'($urandom_range(0, 3));
      end
      for (int i = 0; i < 4; i++) begin
        req[i] = ($urandom_range(0, 5) == 0);
        clr[i] = ($urandom_range(0, 19) == 0);
      end
      applyStimulus(req, $urandom, clr, pin_en_k, pin_sel_k);
    end
  endtask

  // Monitor: compare the DUT against the oldest prediction just after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge I_clk);
      #1;
      if (I_rst_n && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bus.I_req = '0; bus.I_data = '0; bus.I_clr = '0; bus.I_pin_en = 1'b0; bus.I_pin_sel = '0;
    modelReset();
    repeat (2) @(negedge I_clk);
    releaseReset();
    idleCycles(6);

    // Single write, then a three-slot rotation that skips slot 2.
    applyStimulus(4'b0100, 32'h00A5_0000, 4'h0, 1'b0, 2'd0);
    idleCycles(8);
    applyStimulus(4'b1011, 32'h4400_2211, 4'b0100, 1'b0, 2'd0);
    idleCycles(18);

    // Clear slot 1 while it is on screen.
    for (int t = 0; t < 20 && !(m_busy && m_cur == 1); t++) idleCycles(1);
    applyStimulus(4'h0, 32'h0, 4'b0010, 1'b0, 2'd0);
    idleCycles(3);

    // Request/clear collision on slot 0.
    applyStimulus(4'b0001, 32'h0000_0077, 4'b0001, 1'b0, 2'd0);
    idleCycles(3);

    // Pin slot 3, rewrite it while pinned, then resume rotation.
    applyStimulus(4'b0011, 32'h0000_2211, 4'h0, 1'b0, 2'd0);
    pin_en_k = 1'b1; pin_sel_k = 2'd3;
    idleCycles(22);
    applyStimulus(4'b1000, 32'h5500_0000, 4'h0, 1'b1, 2'd3);
    idleCycles(4);
    pin_en_k = 1'b0;
    idleCycles(14);

    // Held request alternates acks.
    repeat (6) applyStimulus(4'b0010, 32'h0000_3300, 4'h0, 1'b0, 2'd0);
    idleCycles(3);

    // Clear everything back to idle.
    applyStimulus(4'h0, 32'h0, 4'b1111, 1'b0, 2'd0);
    idleCycles(4);

    randomPhase(400);

    // Asynchronous reset between edges, mid-dwell.
    applyStimulus(4'b1111, 32'h1234_5678, 4'h0, 1'b0, 2'd0);
    idleCycles(2);
    @(posedge I_clk);
    #3;
    I_rst_n = 1'b0;
    exp_q.delete();
    #1;
    checkField("rst_busy", 32'(bus.O_busy),     32'h0);
    checkField("rst_show", 32'(bus.O_show_num), 32'h0);
    checkField("rst_src",  32'(bus.O_src),      32'h0);
    checkField("rst_ack",  32'(bus.O_ack),      32'h0);
    repeat (2) @(negedge I_clk);
    releaseReset();
    idleCycles(4);

    randomPhase(300);

    idleCycles(2);
    @(posedge I_clk);
    #3;
    checkField("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/disp_scheduler.md
# disp_scheduler

Time-shares the two-digit seven-segment display driver among up to four requesters (e.g. CPU MMIO register, PC debug tap, switch echo, fault code). Each requester posts an 8-bit value through a req/ack handshake into its own slot. The scheduler rotates the display round-robin across valid slots with a programmable dwell time, and supports a pinned mode that locks one slot on screen. Its O_show_num feeds the display driver's 8-bit show-number input directly.

## Interface
- C_NUM_SRC, 4: number of requesters (fixed at 4 for this revision; slot index 2 bits).
- C_DWELL, 50_000_000: display cycles per slot in rotation; must be >= 2.
- C_CNT_W, 32: dwell counter width; must hold C_DWELL-1.
- I_clk  in  1  system clock.
- I_rst_n  in  1  reset, asynchronous, active-low.
- I_req  in  4  per-source write request, level.
- I_data  in  32  packed source data; source i on bits [8i+7:8i].
- I_clr  in  4  per-source slot clear, one-cycle pulse.
- I_pin_en  in  1  1 = pinned mode.
- I_pin_sel  in  2  slot shown while pinned.
- O_ack  out  4  per-source one-cycle write acknowledge.
- O_show_num  out  8  value to display driver.
- O_src  out  2  index of slot currently shown.
- O_busy  out  1  1 = a slot is on screen (state SHOW).

## Operation
- Slots: slot_data[i] (8 b), slot_vld[i].
- Write: at a clock edge where I_req[i]=1 and O_ack[i]=0, slot_data[i] <= I_data[i], slot_vld[i] <= 1, and O_ack[i] <= 1 for exactly one cycle. A request held high therefore re-captures every second cycle; sources drop I_req on seeing O_ack.
- Clear: I_clr[i]=1 sets slot_vld[i] <= 0. If I_clr[i] and a capturing I_req[i] coincide, clear wins: no capture and no ack.
- FSM has two states, IDLE and SHOW.
  - IDLE: O_busy=0, O_show_num=8'h00. When any slot_vld is set, go to SHOW on the lowest valid index (rotation mode) or I_pin_sel (pinned mode, only if that slot is valid). Counter = 0.
  - SHOW, rotation: counter increments each cycle.
    - At counter == C_DWELL-1: cur <= next valid slot searching cur+1, cur+2, ... with wrap; if cur is the only valid slot, keep cur. Counter <= 0 in both cases.
  - SHOW, current slot invalidated (clear): next edge moves to the next valid slot (same search) with counter 0, or to IDLE if none remain.
  - SHOW, pinned: cur <= I_pin_sel whenever slot_vld[I_pin_sel]=1; counter held at 0. If the pinned slot is invalid, go to IDLE.
  - Leaving pinned mode: resume rotation from cur with counter 0.
- O_show_num <= slot_data[cur] every cycle in SHOW, so a rewrite of the displayed slot appears without waiting for the dwell to end. O_src <= cur.

## Timing
- Reset values: all slot_vld=0, slot_data=0, state IDLE, cur=0, counter=0, O_ack=0, O_show_num=8'h00, O_src=0, O_busy=0.
- Reset is asynchronous; asserting it mid-operation returns all of the above immediately.
- Write latency: req sampled at edge E → slot valid and O_ack=1 after E → (from IDLE) SHOW, O_busy=1 and O_show_num = data after E+1.
- Rewrite of the displayed slot: new O_show_num visible after edge E+1.
- Dwell: each slot is on screen for exactly C_DWELL cycles in rotation.
- Clear of the shown slot at edge E: slot invalid after E; switch or IDLE after E+1.
- All outputs are registered; there is no combinational input→output path.

## Structure
- Shared package disp_pkg holds:
  - the state enum (IDLE, SHOW);
  - C_NUM_SRC and the slot index width;
  - the blank value 8'h00.
- One sub-module, rr_pick: purely combinational. Takes a 4-bit valid vector and a 2-bit start index; returns the first valid index strictly after start (wrapping, returning start itself last) plus a found flag. It is used for both the dwell-expiry switch and the clear-driven switch.

## Test plan
All tests use C_DWELL=4.
- Reset/idle: release reset with no activity → O_show_num=8'h00, O_busy=0, O_ack=0 indefinitely.
- Single write: I_req[2]=1 with data 8'hA5 for one cycle → O_ack[2] pulses once; O_src=2 and O_show_num=8'hA5 two edges after the sample. Stays there with no other slots valid.
- Rotation: slots 0=8'h11, 1=8'h22, 3=8'h44 valid → O_show_num sequence 11,22,44,11 with 4 cycles each; slot 2 is skipped.
- Clear and collision:
  - Clear slot 1 while it is shown → slot 3 is shown the next cycle.
  - Simultaneous I_req[0] and I_clr[0] → no ack, slot 0 invalid.
  - Clear all slots → IDLE, 8'h00.
- Pinned mode: I_pin_en=1 with I_pin_sel=3 → 8'h44 held for more than 20 cycles.
  - Rewrite slot 3 to 8'h55 → 55 shown after 2 edges.
  - Drop I_pin_en → rotation resumes 11 after 4 cycles.
- Handshake and reset:
  - Hold I_req[1] high for 6 cycles → O_ack[1] alternates 1,0,1,0,1,0.
  - Assert I_rst_n low mid-dwell → all outputs at reset values asynchronously.
